// File: rtl/voice_pkg.sv
// voice_pkg: shared constants for the voice scheduler.
//   state_t / IDLE / SCAN : scheduler FSM encoding
//   NOTE_DIV              : half-period divisor counts at 50 MHz, C4..C5
//   note_div()            : divisor lookup by key index
package voice_pkg;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t SCAN = 1'b1;

    localparam int NOTE_W = 17;

    localparam logic [NOTE_W-1:0] NOTE_DIV [0:7] = '{
        17'd95557, 17'd85131, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50619, 17'd47778
    };

    function automatic logic [NOTE_W-1:0] note_div(input logic [2:0] k);
        return NOTE_DIV[k];
    endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// voice_scheduler_if: chord sampling request and voice outputs.
//   chord      : held-key levels, one bit per key
//   tick       : one-cycle chord sample strobe
//   voice_div  : per-voice divisor, slice v = voice v
//   voice_note : per-voice owning key index, 3 bits per voice
//   voice_gate : per-voice active flag
//   busy       : scan in progress
//   overflow   : tick dropped because a scan was running
// master drives chord/tick; slave (the scheduler) drives the rest.
interface voice_scheduler_if #(
    parameter int NUM_KEYS   = 8,
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 17
);
    logic [NUM_KEYS-1:0]         chord;
    logic                        tick;
    logic [NUM_VOICES*DIV_W-1:0] voice_div;
    logic [NUM_VOICES*3-1:0]     voice_note;
    logic [NUM_VOICES-1:0]       voice_gate;
    logic                        busy;
    logic                        overflow;

    modport master (
        output chord, tick,
        input  voice_div, voice_note, voice_gate, busy, overflow
    );

    modport slave (
        input  chord, tick,
        output voice_div, voice_note, voice_gate, busy, overflow
    );
endinterface

// File: rtl/voice_pick.sv
// voice_pick: combinational voice selection.
//   gate       : per-voice active flags
//   age        : per-voice age counters
//   free_idx   : lowest-index voice with gate low
//   free_found : at least one voice is free
//   oldest_idx : highest-age voice, ties resolved to the lowest index
module voice_pick #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 3,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_VOICES-1:0]            gate,
    input  logic [NUM_VOICES-1:0][AGE_W-1:0] age,
    output logic [IDX_W-1:0]                 free_idx,
    output logic                             free_found,
    output logic [IDX_W-1:0]                 oldest_idx
);
    logic [AGE_W-1:0] best;

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        oldest_idx = '0;
        best       = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (!gate[v] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(v);
            end
            // strict compare keeps the earliest index on ties
            if (age[v] > best) begin
                best       = age[v];
                oldest_idx = IDX_W'(v);
            end
        end
    end
endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: assigns held keys to a small pool of tone voices.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : voice_scheduler_if.slave (chord/tick in, voice outputs out)
// A tick snapshots the chord; the following NUM_KEYS cycles scan one key
// per cycle, releasing voices on key-up and allocating on key-down.
// Build option: define VOICE_STEAL_EN to steal the oldest voice when all
// voices are gated; otherwise such presses are dropped.
module voice_scheduler
    import voice_pkg::*;
#(
    parameter int NUM_KEYS   = 8,
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 17,
    parameter int AGE_W      = 3
) (
    input logic              clk,
    input logic              rst_n,
    voice_scheduler_if.slave bus
);
    localparam int KW    = (NUM_KEYS > 1)   ? $clog2(NUM_KEYS)   : 1;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    state_t                           state;
    logic [KW-1:0]                    kidx;
    logic [NUM_KEYS-1:0]              snap, prev;
    logic [NUM_VOICES-1:0]            gate, gate_nx;
    logic [NUM_VOICES-1:0][DIV_W-1:0] div, div_nx;
    logic [NUM_VOICES-1:0][2:0]       note, note_nx;
    logic [NUM_VOICES-1:0][AGE_W-1:0] age, age_nx;

    logic             do_press, do_release, alloc;
    logic [IDX_W-1:0] alloc_idx, free_idx, oldest_idx;
    logic             free_found;

    voice_pick #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_pick (
        .gate       (gate),
        .age        (age),
        .free_idx   (free_idx),
        .free_found (free_found),
        .oldest_idx (oldest_idx)
    );

`ifndef VOICE_STEAL_EN
    logic unused_oldest;
    assign unused_oldest = ^oldest_idx;
`endif

    // Next voice state for the key under scan
    always_comb begin
        gate_nx    = gate;
        div_nx     = div;
        note_nx    = note;
        age_nx     = age;
        do_press   = snap[kidx] & ~prev[kidx];
        do_release = prev[kidx] & ~snap[kidx];
        alloc      = 1'b0;
        alloc_idx  = '0;

        if (do_release) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (note[v] == 3'(kidx))
                    gate_nx[v] = 1'b0;
            end
        end

        if (do_press) begin
            if (free_found) begin
                alloc     = 1'b1;
                alloc_idx = free_idx;
            end
`ifdef VOICE_STEAL_EN
            else begin
                alloc     = 1'b1;
                alloc_idx = oldest_idx;
            end
`endif
            if (alloc) begin
                for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                    if (gate[v] && IDX_W'(v) != alloc_idx && age[v] != '1)
                        age_nx[v] = age[v] + AGE_W'(1);
                end
                gate_nx[alloc_idx] = 1'b1;
                note_nx[alloc_idx] = 3'(kidx);
                div_nx[alloc_idx]  = DIV_W'(note_div(3'(kidx)));
                age_nx[alloc_idx]  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            kidx  <= '0;
            snap  <= '0;
            prev  <= '0;
            gate  <= '0;
            div   <= '0;
            note  <= '0;
            age   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.tick) begin
                        snap  <= bus.chord;
                        prev  <= snap;
                        kidx  <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    gate <= gate_nx;
                    div  <= div_nx;
                    note <= note_nx;
                    age  <= age_nx;
                    if (kidx == KW'(NUM_KEYS - 1))
                        state <= IDLE;
                    else
                        kidx <= kidx + KW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Overflow is flagged in the same cycle as the rejected tick
    assign bus.busy       = (state == SCAN);
    assign bus.overflow   = bus.tick && (state == SCAN);
    assign bus.voice_gate = gate;
    assign bus.voice_div  = div;
    assign bus.voice_note = note;

endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: directed scenarios plus randomized chords/ticks,
// checked every cycle against a behavioural voice-allocation model.
module tb_voice_scheduler;
    localparam int NK = 8;
    localparam int NV = 4;
    localparam int DW = 17;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    voice_scheduler_if #(.NUM_KEYS(NK), .NUM_VOICES(NV), .DIV_W(DW)) bus ();

    voice_scheduler #(
        .NUM_KEYS   (NK),
        .NUM_VOICES (NV),
        .DIV_W      (DW),
        .AGE_W      (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int tab [8] = '{95557, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
    bit          m_busy = 1'b0;
    int          m_k    = 0;
    bit [NK-1:0] m_snap = '0;
    bit [NK-1:0] m_prev = '0;
    bit          m_gate [NV];
    int          m_note [NV];
    int          m_div  [NV];
    int          m_age  [NV];

    function automatic void model_clear();
        m_busy = 1'b0; m_k = 0; m_snap = '0; m_prev = '0;
        for (int v = 0; v < NV; v++) begin
            m_gate[v] = 1'b0; m_note[v] = 0; m_div[v] = 0; m_age[v] = 0;
        end
    endfunction

    function automatic void model_key(input int k);
        int target;
        int best;
        bit pressed;
        bit released;
        pressed  = m_snap[k] && !m_prev[k];
        released = m_prev[k] && !m_snap[k];
        if (released)
            for (int v = 0; v < NV; v++)
                if (m_note[v] == k) m_gate[v] = 1'b0;
        if (pressed) begin
            target = -1;
            for (int v = 0; v < NV; v++)
                if (!m_gate[v]) begin target = v; break; end
`ifdef VOICE_STEAL_EN
            if (target < 0) begin
                best = -1;
                for (int v = 0; v < NV; v++)
                    if (m_age[v] > best) begin best = m_age[v]; target = v; end
            end
`endif
            if (target >= 0) begin
                for (int v = 0; v < NV; v++)
                    if (m_gate[v] && v != target && m_age[v] < (1 << AW) - 1) m_age[v]++;
                m_gate[target] = 1'b1;
                m_note[target] = k;
                m_div[target]  = tab[k];
                m_age[target]  = 0;
            end
        end
    endfunction

    initial model_clear();

    always @(posedge clk) begin
        if (!rst_n) model_clear();
        else if (!m_busy) begin
            if (bus.tick) begin
                m_prev = m_snap;
                m_snap = bus.chord;
                m_busy = 1'b1;
                m_k    = 0;
            end
        end else begin
            model_key(m_k);
            if (m_k == NK - 1) m_busy = 1'b0;
            else m_k++;
        end
    end

    function automatic logic [NV*DW-1:0] exp_div();
        logic [NV*DW-1:0] r;
        for (int v = 0; v < NV; v++) r[v*DW +: DW] = DW'(m_div[v]);
        return r;
    endfunction

    function automatic logic [NV*3-1:0] exp_note();
        logic [NV*3-1:0] r;
        for (int v = 0; v < NV; v++) r[v*3 +: 3] = 3'(m_note[v]);
        return r;
    endfunction

    function automatic logic [NV-1:0] exp_gate();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_gate[v];
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",       bus.busy,       m_busy);
            check("overflow",   bus.overflow,   bus.tick && m_busy);
            check("voice_gate", bus.voice_gate, exp_gate());
            check("voice_note", bus.voice_note, exp_note());
            check("voice_div",  bus.voice_div,  exp_div());
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic t, input logic [NK-1:0] c, input logic r);
        @(posedge clk);
        #2;
        bus.tick  = t;
        bus.chord = c;
        rst_n     = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, bus.chord, 1'b1);
    endtask

    initial begin
        int nb;
        logic [NK-1:0] c;
        logic t, r;
        bus.tick  = 1'b0;
        bus.chord = '0;
        step(1'b0, '0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_gate", bus.voice_gate, 0);
        check("rst_div",  bus.voice_div, 0);

        // single key press
        step(1'b1, 8'h01, 1'b1);
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h01, 1'b1);
            @(negedge clk);
            if (bus.busy) nb++;
        end
        check("busy_len", nb, 8);
        check("v0_gate", bus.voice_gate, 4'b0001);
        check("v0_note", bus.voice_note[2:0], 0);
        check("v0_div",  bus.voice_div[DW-1:0], 95557);

        // four keys, then release key 1
        step(1'b0, '0, 1'b0);
        step(1'b1, 8'h0F, 1'b1);
        idle(10);
        @(negedge clk);
        check("four_notes", bus.voice_note, 12'h688);
        check("four_gates", bus.voice_gate, 4'hF);
        step(1'b1, 8'h0D, 1'b1);
        idle(10);
        @(negedge clk);
        check("release_k1", bus.voice_gate, 4'b1101);

        // fifth key with all voices gated
        step(1'b0, '0, 1'b0);
        step(1'b1, 8'h0F, 1'b1);
        idle(10);
        step(1'b1, 8'h1F, 1'b1);
        idle(10);
        @(negedge clk);
        check("full_gates", bus.voice_gate, 4'hF);
`ifdef VOICE_STEAL_EN
        check("steal_note", bus.voice_note[2:0], 4);
        check("steal_div",  bus.voice_div[DW-1:0], 63776);
`else
        check("drop_note", bus.voice_note[2:0], 0);
        check("drop_div",  bus.voice_div[DW-1:0], 95557);
`endif

        // tick during the third scan cycle
        step(1'b0, '0, 1'b0);
        step(1'b1, 8'h3C, 1'b1);
        step(1'b0, 8'h3C, 1'b1);
        step(1'b0, 8'h3C, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        @(negedge clk);
        check("ovf_pulse", bus.overflow, 1);
        step(1'b0, 8'hFF, 1'b1);
        @(negedge clk);
        check("ovf_clear", bus.overflow, 0);
        idle(5);
        @(negedge clk);
        check("ovf_sched", bus.busy, 0);
        check("ovf_notes", bus.voice_note, 12'hB1A);

        // reset during the fourth scan cycle
        step(1'b0, '0, 1'b0);
        step(1'b1, 8'h0F, 1'b1);
        step(1'b0, 8'h0F, 1'b1);
        step(1'b0, 8'h0F, 1'b1);
        step(1'b0, 8'h0F, 1'b1);
        step(1'b0, 8'h0F, 1'b0);
        step(1'b0, 8'h80, 1'b1);
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_gate", bus.voice_gate, 0);
        check("abort_note", bus.voice_note, 0);
        check("abort_div",  bus.voice_div, 0);
        step(1'b1, 8'h80, 1'b1);
        idle(10);
        @(negedge clk);
        check("k7_gate", bus.voice_gate, 4'b0001);
        check("k7_note", bus.voice_note[2:0], 7);
        check("k7_div",  bus.voice_div[DW-1:0], 47778);

        // randomized chords and ticks
        c = bus.chord;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) c = NK'($urandom);
            t = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 199) != 0);
            step(t, c, r);
        end
        idle(12);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
